// File: rtl/ecc_enc_stream.sv
// ecc_enc_stream: two-stage streaming Hamming SECDED encoder.
// Each accepted information word is encoded into an (n+1)-bit codeword
// (Hamming positions 1..n plus overall parity p0). The per-word injection
// mask is XORed onto the codeword so downstream decoders can be exercised.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and
// ready are both high. Once m_valid_o is high, m_valid_o/m_d_o/m_inj_o
// hold until m_ready_i is sampled high. s_ready_o never depends on
// s_valid_i.
module ecc_enc_stream #(
  parameter int K      = 8,
  parameter bit P0_LSB = 1'b1,
  // Smallest m with 2^m >= m + K + 1.
  localparam int M = (K <= 1)    ? 2  :
                     (K <= 4)    ? 3  :
                     (K <= 11)   ? 4  :
                     (K <= 26)   ? 5  :
                     (K <= 57)   ? 6  :
                     (K <= 120)  ? 7  :
                     (K <= 247)  ? 8  :
                     (K <= 502)  ? 9  :
                     (K <= 1013) ? 10 :
                     (K <= 2036) ? 11 : 12,
  localparam int N = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [K-1:0] s_d_i,
  input  logic [N:0]   s_inj_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [N:0]   m_d_o,
  output logic         m_inj_o,
  output logic [15:0]  cnt_o
);

  // S1: raw word and mask
  logic         v1_q, v1_d;
  logic [K-1:0] d1_q, d1_d;
  logic [N:0]   inj1_q, inj1_d;
  // S2: injected codeword
  logic         v2_q, v2_d;
  logic [N:0]   cw2_q, cw2_d;
  logic         inj2_q, inj2_d;
  logic [15:0]  cnt_q, cnt_d;

  logic         in_xfer;
  logic         out_xfer;
  logic         move;
  logic [N:1]   pos;
  logic [N:0]   enc;

  // Stage handshake: S1 may advance whenever S2 is empty or draining.
  always_comb begin
    s_ready_o = rst_ni & (~v1_q | ~v2_q | m_ready_i);
    in_xfer   = s_valid_i & s_ready_o;
    out_xfer  = v2_q & m_ready_i;
    move      = v1_q & (~v2_q | m_ready_i);
  end

  // Encoder: scatter info bits into non-power-of-2 positions, then parity.
  always_comb begin
    int   k;
    logic par;
    pos = '0;
    k   = 0;
    par = 1'b0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = d1_q[k];
        k      = k + 1;
      end
    end
    for (int j = 0; j < M; j++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if ((((p >> j) & 1) != 0) && ((p & (p - 1)) != 0)) begin
          par = par ^ pos[p];
        end
      end
      pos[1 << j] = par;
    end
    if (P0_LSB) enc = {pos, ^pos};
    else        enc = {^pos, pos};
  end

  // Next-state for both stages and the delivered-word counter.
  always_comb begin
    v1_d   = v1_q;
    d1_d   = d1_q;
    inj1_d = inj1_q;
    v2_d   = v2_q;
    cw2_d  = cw2_q;
    inj2_d = inj2_q;
    cnt_d  = cnt_q;
    if (in_xfer) begin
      v1_d   = 1'b1;
      d1_d   = s_d_i;
      inj1_d = s_inj_i;
    end else if (move) begin
      v1_d   = 1'b0;
    end
    if (move) begin
      v2_d   = 1'b1;
      cw2_d  = enc ^ inj1_q;
      inj2_d = |inj1_q;
    end else if (out_xfer) begin
      v2_d   = 1'b0;
    end
    if (out_xfer) cnt_d = cnt_q + 16'd1;
  end

  // Pipeline registers; reset drops all in-flight words at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      inj1_q <= '0;
      v2_q   <= 1'b0;
      cw2_q  <= '0;
      inj2_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      d1_q   <= d1_d;
      inj1_q <= inj1_d;
      v2_q   <= v2_d;
      cw2_q  <= cw2_d;
      inj2_q <= inj2_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs come straight from S2 registers.
  always_comb begin
    m_valid_o = v2_q;
    m_d_o     = cw2_q;
    m_inj_o   = inj2_q;
    cnt_o     = cnt_q;
  end

endmodule

// File: tb/tb_ecc_enc_stream.sv
`timescale 1ns/1ps
module tb_ecc_enc_stream;
  localparam int K = 8;
  localparam int M = 4;
  localparam int N = 12;
  localparam int W = N + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // main DUT (p0 on bit 0)
  logic         s_valid, s_ready, m_valid, m_ready, m_inj;
  logic [K-1:0] s_d;
  logic [W-1:0] s_inj, m_d;
  logic [15:0]  cnt;
  // second DUT (p0 on MSB)
  logic         b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_inj;
  logic [K-1:0] b_s_d;
  logic [W-1:0] b_s_inj, b_m_d;
  logic [15:0]  b_cnt;

  ecc_enc_stream #(.K(K), .P0_LSB(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_d_i(s_d), .s_inj_i(s_inj),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_d_o(m_d), .m_inj_o(m_inj),
    .cnt_o(cnt)
  );

  ecc_enc_stream #(.K(K), .P0_LSB(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .s_d_i(b_s_d), .s_inj_i(b_s_inj),
    .m_valid_o(b_m_valid), .m_ready_i(b_m_ready), .m_d_o(b_m_d), .m_inj_o(b_m_inj),
    .cnt_o(b_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_inj_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: parity bits chosen so the XOR of all set positions is 0.
  function automatic logic [W-1:0] ref_enc(input logic [K-1:0] d);
    logic [W-1:0] c;
    int syn;
    int k;
    c   = '0;
    syn = 0;
    k   = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        if (d[k]) syn = syn ^ p;
        k++;
      end
    end
    for (int j = 0; j < M; j++) c[1 << j] = ((syn >> j) & 1) != 0;
    c[0] = ^c[N:1];
    return c;
  endfunction

  // SECDED decoder: returns {kind[1:0], data}; kind 0=clean, 1=single, 2=double.
  function automatic logic [K+1:0] secded_dec(input logic [W-1:0] cw);
    logic [W-1:0] c;
    logic [K-1:0] d;
    logic [1:0]   kind;
    int syn;
    int k;
    c   = cw;
    syn = 0;
    for (int p = 1; p <= N; p++) if (c[p]) syn = syn ^ p;
    if (syn == 0 && !(^c)) kind = 2'd0;
    else if (^c) begin
      kind = 2'd1;
      if (syn <= N) c[syn] = ~c[syn];
    end else kind = 2'd2;
    d = '0;
    k = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    return {kind, d};
  endfunction

  // Monitor: compare every output transfer against the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) check_eq("spurious_out", m_valid, 0);
      else begin
        check_eq("out_data", m_d, exp_q.pop_front());
        check_eq("out_inj", m_inj, exp_inj_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [K-1:0] d, input logic [W-1:0] inj);
    exp_q.push_back(ref_enc(d) ^ inj);
    exp_inj_q.push_back(|inj);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [K-1:0] d, input logic [W-1:0] inj);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_d     = d;
    s_inj   = inj;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check_eq("send_timeout", s_ready, 1);
    else push_exp(d, inj);
    tick();
    s_valid = 1'b0;
    s_d     = K'($urandom);
    s_inj   = W'($urandom);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 300) begin
      tick();
      t++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [K-1:0] bp_words[5] = '{8'h11, 8'h22, 8'hA5, 8'h5A, 8'hC3};
  logic [K-1:0] c_in[3]     = '{8'h00, 8'h01, 8'hFF};
  logic [W-1:0] c_out[3]    = '{13'h0000, 13'h000F, 13'h1EEE};
  bit rdy_run;

  initial begin
    int idx;
    int t;
    logic [K+1:0] dec;
    logic [W-1:0] inj;
    rst_n = 1'b1;
    s_valid = 1'b0; s_d = '0; s_inj = '0; m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_d = '0; b_s_inj = '0; b_m_ready = 1'b1;
    rdy_run = 1'b0;

    // asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_d", m_d, 0);
    check_eq("rst_m_inj", m_inj, 0);
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_s_ready", s_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // p0-at-MSB bit order on the second instance
    b_s_valid = 1'b1; b_s_d = 8'h01; b_s_inj = '0;
    @(negedge clk);
    check_eq("b_s_ready", b_s_ready, 1);
    tick();
    b_s_valid = 1'b0;
    check_eq("b_lat_early", b_m_valid, 0);
    tick();
    check_eq("b_m_valid", b_m_valid, 1);
    check_eq("b_m_d_msb_p0", b_m_d, 13'h1007);
    tick();
    check_eq("b_cnt", b_cnt, 1);

    // backpressure: only two words fit while the sink stalls
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      s_valid = 1'b1; s_d = bp_words[idx]; s_inj = '0;
      @(negedge clk);
      if (s_ready) begin
        push_exp(bp_words[idx], '0);
        idx++;
      end
      tick();
    end
    check_eq("bp_accepted", idx, 2);
    check_eq("bp_s_ready_low", s_ready, 0);
    fork
      begin
        m_ready = 1'b1;
        t = 0;
        while (idx < 5 && t < 50) begin
          s_valid = 1'b1; s_d = bp_words[idx];
          @(negedge clk);
          if (s_ready) begin
            push_exp(bp_words[idx], '0);
            idx++;
          end
          tick();
          t++;
        end
        s_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_eq("bp_no_gap", m_valid, 1);
        end
      end
    join
    wait_drain();
    check_eq("bp_cnt", cnt, 5);

    // fixed encodings and two-cycle latency
    for (int i = 0; i < 3; i++) begin
      send(c_in[i], '0);
      check_eq("lat_early", m_valid, 0);
      tick();
      check_eq("lat_valid", m_valid, 1);
      check_eq("enc_const", m_d, c_out[i]);
      wait_drain();
    end

    // error injection and decoder loopback
    send(8'hFF, 13'h0008);
    tick();
    check_eq("inj_m_d", m_d, 13'h1EE6);
    check_eq("inj_flag", m_inj, 1);
    dec = secded_dec(m_d);
    check_eq("dec_kind_single", dec[K+1:K], 2'd1);
    check_eq("dec_data", dec[K-1:0], 8'hFF);
    wait_drain();

    // random words, idle gaps and random sink stalls
    rdy_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin
            s_d = K'($urandom); s_inj = W'($urandom);
            tick();
          end
          inj = '0;
          if ($urandom_range(0, 2) == 0) inj = W'($urandom);
          send(K'($urandom), inj);
        end
        rdy_run = 1'b0;
      end
      begin
        while (rdy_run) begin
          tick();
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    wait_drain();

    // reset with both stages full
    m_ready = 1'b0;
    send(8'h3C, '0);
    send(8'hC3, '0);
    check_eq("full_m_valid", m_valid, 1);
    check_eq("full_s_ready", s_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_inj_q.delete();
    check_eq("mid_rst_m_valid", m_valid, 0);
    check_eq("mid_rst_m_d", m_d, 0);
    check_eq("mid_rst_cnt", cnt, 0);
    check_eq("mid_rst_s_ready", s_ready, 0);
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("post_rst_idle", m_valid, 0);
    end
    check_eq("post_rst_cnt", cnt, 0);

    // counter wrap
    for (int i = 0; i < 65535; i++) send(K'($urandom), '0);
    wait_drain();
    check_eq("cnt_ffff", cnt, 16'hFFFF);
    send(8'h5A, '0);
    wait_drain();
    check_eq("cnt_wrap", cnt, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
